// File: rtl/itype_exec_unit_pkg.sv
// Shared definitions for the RV OP-IMM execution unit: opcode/funct3 codes,
// controller states, shifter step kinds and the shift-amount width helper.
package itype_exec_unit_pkg;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SLTI  = 3'b010;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_XORI  = 3'b100;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ANDI  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_e;

    function automatic int shamt_w(input int xlen);
        if (xlen == 32'sd64) begin
            return 32'sd6;
        end else begin
            return 32'sd5;
        end
    endfunction

endpackage

// File: rtl/itype_exec_unit_alu.sv
// Combinational OP-IMM datapath: decode, legality, one-shot result and a
// single-bit shift step used by the iterative shifter.
module itype_alu
    import itype_exec_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHAMT_W = shamt_w(XLEN)
) (
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [11:0]        imm12,
    input  logic [XLEN-1:0]    rs1_data,
    output logic [XLEN-1:0]    result,
    output logic               illegal,
    output logic               is_shift,
    output logic [SHAMT_W-1:0] shamt,
    output shift_e             shift_kind,
    input  logic [XLEN-1:0]    step_in,
    input  shift_e             step_kind,
    input  logic               step_fill,
    output logic [XLEN-1:0]    step_out
);

    // At XLEN=64 instr[25] is the top shamt bit, so it is excluded from funct7.
    localparam logic [6:0] F7_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] raw_s;
    logic [6:0]      f7_chk_s;
    logic            bad_f7_s;

    assign imm_s    = {{(XLEN-12){imm12[11]}}, imm12};
    assign shamt    = imm12[SHAMT_W-1:0];
    assign f7_chk_s = imm12[11:5] & F7_MASK;

    // Operation select and shift-encoding legality.
    always_comb begin
        raw_s      = {XLEN{1'b0}};
        bad_f7_s   = 1'b0;
        is_shift   = 1'b0;
        shift_kind = SH_SLL;
        case (funct3)
            F3_ADDI:  raw_s = rs1_data + imm_s;
            F3_SLTI:  raw_s = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(imm_s))};
            F3_SLTIU: raw_s = {{(XLEN-1){1'b0}}, (rs1_data < imm_s)};
            F3_XORI:  raw_s = rs1_data ^ imm_s;
            F3_ORI:   raw_s = rs1_data | imm_s;
            F3_ANDI:  raw_s = rs1_data & imm_s;
            F3_SLLI: begin
                is_shift   = 1'b1;
                shift_kind = SH_SLL;
                bad_f7_s   = (f7_chk_s != 7'b0000000);
                raw_s      = rs1_data << shamt;
            end
            F3_SRXI: begin
                is_shift = 1'b1;
                bad_f7_s = ((f7_chk_s & 7'b1011111) != 7'b0000000);
                if (imm12[10]) begin
                    shift_kind = SH_SRA;
                    raw_s      = XLEN'($signed(rs1_data) >>> shamt);
                end else begin
                    shift_kind = SH_SRL;
                    raw_s      = rs1_data >> shamt;
                end
            end
            default: bad_f7_s = 1'b1;
        endcase
    end

    assign illegal = bad_f7_s | (opcode != OPCODE_OP_IMM);
    assign result  = illegal ? {XLEN{1'b0}} : raw_s;

    // One-bit shift step; arithmetic steps refill with the operand's original sign.
    always_comb begin
        case (step_kind)
            SH_SLL:  step_out = {step_in[XLEN-2:0], 1'b0};
            SH_SRL:  step_out = {1'b0, step_in[XLEN-1:1]};
            SH_SRA:  step_out = {step_fill, step_in[XLEN-1:1]};
            default: step_out = step_in;
        endcase
    end

endmodule

// File: rtl/itype_exec_unit.sv
// RV I-type (OP-IMM) execution unit with valid/ready handshakes on both sides
// and an optional one-bit-per-cycle shifter.
module itype_exec_unit
    import itype_exec_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd,
    output logic            illegal,
    output logic            busy
);

    localparam int SHAMT_W = shamt_w(XLEN);

    state_e              state_r, state_n;
    logic [XLEN-1:0]     result_r, result_n;
    logic [4:0]          rd_r, rd_n;
    logic                illegal_r, illegal_n;
    logic [XLEN-1:0]     shreg_r, shreg_n;
    logic [SHAMT_W-1:0]  cnt_r, cnt_n;
    shift_e              kind_r, kind_n;
    logic                fill_r, fill_n;
    logic                out_valid_r;
    logic                busy_r;

    logic [XLEN-1:0]     alu_result_s;
    logic                alu_illegal_s;
    logic                alu_is_shift_s;
    logic [SHAMT_W-1:0]  alu_shamt_s;
    shift_e              alu_kind_s;
    logic [XLEN-1:0]     step_in_s;
    shift_e              step_kind_s;
    logic                step_fill_s;
    logic [XLEN-1:0]     step_out_s;
    logic                in_shift_s;
    logic [SHAMT_W-1:0]  cnt_dec_s;
    logic                accept_s;
    logic                out_xfer_s;
    logic                serial_go_s;
    logic                unused_rs1_field_s;

    itype_alu #(.XLEN(XLEN)) u_alu (
        .opcode     (instr[6:0]),
        .funct3     (instr[14:12]),
        .imm12      (instr[31:20]),
        .rs1_data   (rs1_data),
        .result     (alu_result_s),
        .illegal    (alu_illegal_s),
        .is_shift   (alu_is_shift_s),
        .shamt      (alu_shamt_s),
        .shift_kind (alu_kind_s),
        .step_in    (step_in_s),
        .step_kind  (step_kind_s),
        .step_fill  (step_fill_s),
        .step_out   (step_out_s)
    );

    assign unused_rs1_field_s = ^instr[19:15];

    // The single step helper serves the accept edge (rs1) and every SHIFT cycle.
    assign in_shift_s  = (state_r == ST_SHIFT);
    assign step_in_s   = in_shift_s ? shreg_r : rs1_data;
    assign step_kind_s = in_shift_s ? kind_r : alu_kind_s;
    assign step_fill_s = in_shift_s ? fill_r : rs1_data[XLEN-1];
    assign cnt_dec_s   = (in_shift_s ? cnt_r : alu_shamt_s) - SHAMT_W'(1);

    assign serial_go_s = (SERIAL_SHIFT != 0) && alu_is_shift_s && !alu_illegal_s
                         && (alu_shamt_s != {SHAMT_W{1'b0}});

    // Input readiness per controller state.
    always_comb begin
        case (state_r)
            ST_IDLE:  in_ready = 1'b1;
            ST_HOLD:  in_ready = out_ready;
            ST_SHIFT: in_ready = 1'b0;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept_s   = in_valid & in_ready;
    assign out_xfer_s = out_valid_r & out_ready;

    // Next-state: an accept (IDLE or back-to-back from HOLD) loads the new op.
    always_comb begin
        state_n   = state_r;
        result_n  = result_r;
        rd_n      = rd_r;
        illegal_n = illegal_r;
        shreg_n   = shreg_r;
        cnt_n     = cnt_r;
        kind_n    = kind_r;
        fill_n    = fill_r;
        if (accept_s) begin
            rd_n      = instr[11:7];
            illegal_n = alu_illegal_s;
            if (serial_go_s) begin
                kind_n  = alu_kind_s;
                fill_n  = rs1_data[XLEN-1];
                shreg_n = step_out_s;
                cnt_n   = cnt_dec_s;
                if (cnt_dec_s == {SHAMT_W{1'b0}}) begin
                    result_n = step_out_s;
                    state_n  = ST_HOLD;
                end else begin
                    state_n  = ST_SHIFT;
                end
            end else begin
                result_n = alu_result_s;
                cnt_n    = {SHAMT_W{1'b0}};
                state_n  = ST_HOLD;
            end
        end else begin
            case (state_r)
                ST_SHIFT: begin
                    shreg_n = step_out_s;
                    cnt_n   = cnt_dec_s;
                    if (cnt_dec_s == {SHAMT_W{1'b0}}) begin
                        result_n = step_out_s;
                        state_n  = ST_HOLD;
                    end else begin
                        state_n  = ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (out_xfer_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
                ST_IDLE:  state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset discards any in-flight or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            result_r    <= {XLEN{1'b0}};
            rd_r        <= 5'd0;
            illegal_r   <= 1'b0;
            shreg_r     <= {XLEN{1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            kind_r      <= SH_SLL;
            fill_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            result_r    <= result_n;
            rd_r        <= rd_n;
            illegal_r   <= illegal_n;
            shreg_r     <= shreg_n;
            cnt_r       <= cnt_n;
            kind_r      <= kind_n;
            fill_r      <= fill_n;
            out_valid_r <= (state_n == ST_HOLD);
            busy_r      <= (state_n != ST_IDLE);
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign rd        = rd_r;
    assign illegal   = illegal_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_itype_exec_unit.sv
// Directed bench: serial-shift and barrel-shift instances, a cycle-level
// scoreboard model plus literal expectations for each vector.
module tb_itype_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] instr = 32'd0, rs1_data = 32'd0;
    logic        in_ready, out_valid, illegal, busy;
    logic [31:0] result;
    logic [4:0]  rd;

    logic        b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic [31:0] b_instr = 32'd0, b_rs1 = 32'd0;
    logic        b_in_ready, b_out_valid, b_illegal, b_busy;
    logic [31:0] b_result;
    logic [4:0]  b_rd;

    int passed = 0, total = 0, cyc = 0;
    bit started = 1'b0;

    itype_exec_unit #(.XLEN(32), .SERIAL_SHIFT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .rd(rd), .illegal(illegal), .busy(busy));

    itype_exec_unit #(.XLEN(32), .SERIAL_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr(b_instr), .rs1_data(b_rs1), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .result(b_result), .rd(b_rd), .illegal(b_illegal), .busy(b_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passed++;
        end
    endtask

    // Reference semantics of an OP-IMM instruction at XLEN=32: {illegal, result}.
    function automatic logic [32:0] model(input logic [31:0] ins, input logic [31:0] x);
        logic [31:0] imm, r;
        int sh;
        logic bad;
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = int'(ins[24:20]);
        bad = (ins[6:0] != 7'b0010011);
        r   = 32'd0;
        case (ins[14:12])
            3'd0: r = x + imm;
            3'd2: r = (int'(x) < int'(imm)) ? 32'd1 : 32'd0;
            3'd3: r = (x < imm) ? 32'd1 : 32'd0;
            3'd4: r = x ^ imm;
            3'd6: r = x | imm;
            3'd7: r = x & imm;
            3'd1: begin
                if (ins[31:25] != 7'd0) bad = 1'b1;
                r = x << sh;
            end
            default: begin
                if (ins[31] || ins[29:25] != 5'd0) bad = 1'b1;
                r = ins[30] ? 32'(int'(x) >>> sh) : (x >> sh);
            end
        endcase
        if (bad) r = 32'd0;
        return {bad, r};
    endfunction

    // Serial latency: a legal shift takes shamt cycles, everything else one.
    function automatic int model_lat(input logic [31:0] ins);
        logic [32:0] m;
        m = model(ins, 32'd0);
        if (!m[32] && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) && ins[24:20] != 5'd0)
            return int'(ins[24:20]);
        return 1;
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          a;
        int          lat;
    } exp_t;
    exp_t q[$];

    // Scoreboard: every cycle, outputs must match the oldest accepted instruction.
    always @(negedge clk) begin
        bit mvalid, mready;
        exp_t e;
        logic [32:0] m;
        if (started) begin
            mvalid = (q.size() > 0) && (cyc >= q[0].a + q[0].lat - 1);
            if (q.size() == 0) begin
                chk("mon_idle_out_valid", out_valid, 0);
                chk("mon_idle_busy", busy, 0);
                chk("mon_idle_in_ready", in_ready, 1);
            end else if (mvalid) begin
                chk("mon_out_valid", out_valid, 1);
                chk("mon_result", result, q[0].res);
                chk("mon_rd", rd, q[0].rd);
                chk("mon_illegal", illegal, q[0].ill);
                chk("mon_hold_busy", busy, 1);
                chk("mon_hold_in_ready", in_ready, out_ready);
            end else begin
                chk("mon_shift_out_valid", out_valid, 0);
                chk("mon_shift_busy", busy, 1);
                chk("mon_shift_in_ready", in_ready, 0);
            end
            if (rst) begin
                q.delete();
            end else begin
                mready = (q.size() == 0) || (mvalid && out_ready);
                if (mvalid && out_ready) void'(q.pop_front());
                if (in_valid && mready) begin
                    m     = model(instr, rs1_data);
                    e.res = m[31:0];
                    e.ill = m[32];
                    e.rd  = instr[11:7];
                    e.a   = cyc + 1;
                    e.lat = model_lat(instr);
                    q.push_back(e);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [11:0] imm, input logic [2:0] f3,
                                       input logic [4:0] rdi, input logic [6:0] op);
        return {imm, 5'd1, f3, rdi, op};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] x);
        bit acc;
        acc = 1'b0;
        instr = ins; rs1_data = x; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        if (!acc) chk("issue_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        if (out_valid !== 1'b1) chk("wait_valid_timeout", out_valid, 1);
    endtask

    task automatic exec(input string name, input logic [31:0] ins, input logic [31:0] x,
                        input logic [31:0] er, input logic ei);
        issue(ins, x);
        wait_valid();
        chk({name, "_result"}, result, er);
        chk({name, "_illegal"}, illegal, ei);
        chk({name, "_rd"}, rd, ins[11:7]);
        @(posedge clk); #2;
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] x;
        logic [31:0] er;
        logic        ei;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string n, input logic [11:0] imm, input logic [2:0] f3,
                       input logic [6:0] op, input logic [31:0] x, input logic [31:0] er,
                       input logic ei);
        vec_t v;
        v.name = n;
        v.ins  = mk(imm, f3, 5'(vecs.size() + 3), op);
        v.x = x; v.er = er; v.ei = ei;
        vecs.push_back(v);
    endtask

    initial begin
        localparam logic [6:0] OPI = 7'b0010011;
        add("addi_neg1",   12'hFFF, 3'd0, OPI, 32'd5,        32'd4,        1'b0);
        add("addi_wrap_p", 12'h001, 3'd0, OPI, 32'h7FFFFFFF, 32'h80000000, 1'b0);
        add("addi_wrap_z", 12'h001, 3'd0, OPI, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        add("sltiu_m1",    12'hFFF, 3'd3, OPI, 32'd0,        32'd1,        1'b0);
        add("slti_m1",     12'hFFF, 3'd2, OPI, 32'd0,        32'd0,        1'b0);
        add("slti_neg",    12'hFFF, 3'd2, OPI, 32'hFFFFFFFE, 32'd1,        1'b0);
        add("sltiu_eq",    12'h005, 3'd3, OPI, 32'd5,        32'd0,        1'b0);
        add("xori",        12'h0F0, 3'd4, OPI, 32'h0000FFFF, 32'h0000FF0F, 1'b0);
        add("xori_sext",   12'h800, 3'd4, OPI, 32'h12345678, 32'hEDCBAE78, 1'b0);
        add("ori",         12'h7FF, 3'd6, OPI, 32'd0,        32'h000007FF, 1'b0);
        add("andi",        12'hF0F, 3'd7, OPI, 32'hFFFF1234, 32'hFFFF1204, 1'b0);
        add("srai_4",      12'h404, 3'd5, OPI, 32'h80000000, 32'hF8000000, 1'b0);
        add("srai_pos",    12'h404, 3'd5, OPI, 32'h7FFFFFF0, 32'h07FFFFFF, 1'b0);
        add("srai_1",      12'h401, 3'd5, OPI, 32'h80000001, 32'hC0000000, 1'b0);
        add("srli_31",     12'h01F, 3'd5, OPI, 32'h80000000, 32'h00000001, 1'b0);
        add("slli_0",      12'h000, 3'd1, OPI, 32'h00000001, 32'h00000001, 1'b0);
        add("slli_1",      12'h001, 3'd1, OPI, 32'h00000003, 32'h00000006, 1'b0);
        add("slli_31",     12'h01F, 3'd1, OPI, 32'h00000001, 32'h80000000, 1'b0);
        add("bad_opcode",  12'h005, 3'd0, 7'b0110011, 32'd7, 32'd0,        1'b1);
        add("slli_b25",    12'h023, 3'd1, OPI, 32'd1,        32'd0,        1'b1);
        add("slli_b30",    12'h403, 3'd1, OPI, 32'd1,        32'd0,        1'b1);
        add("srli_b31",    12'h803, 3'd5, OPI, 32'd1,        32'd0,        1'b1);
        add("srai_b25",    12'h423, 3'd5, OPI, 32'd1,        32'd0,        1'b1);

        @(posedge clk); #2;
        started = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_rd", rd, 0);
        chk("reset_illegal", illegal, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        foreach (vecs[i]) exec(vecs[i].name, vecs[i].ins, vecs[i].x, vecs[i].er, vecs[i].ei);

        // Backpressure with a queued instruction, then back-to-back acceptance.
        out_ready = 1'b0;
        issue(mk(12'h005, 3'd0, 5'd7, OPI), 32'd10);
        instr = mk(12'h055, 3'd6, 5'd8, OPI); rs1_data = 32'd0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result_stable", result, 32'd15);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_result", result, 32'h55);
        chk("b2b_rd", rd, 5'd8);
        @(posedge clk); #2;

        // Reset in the second cycle of a 10-step shift.
        issue(mk(12'h00A, 3'd1, 5'd9, OPI), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_shift_out_valid", out_valid, 0);
        chk("rst_shift_busy", busy, 0);
        chk("rst_shift_in_ready", in_ready, 1);
        @(posedge clk); #2;
        exec("addi_after_rst", mk(12'h003, 3'd0, 5'd4, OPI), 32'd2, 32'd5, 1'b0);

        // Reset while a result waits in HOLD: discarded, never transferred.
        out_ready = 1'b0;
        issue(mk(12'h001, 3'd0, 5'd5, OPI), 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hold_out_valid", out_valid, 0);
        chk("rst_hold_result", result, 0);
        chk("rst_hold_rd", rd, 0);
        @(posedge clk); #2;

        // Barrel-shift instance: every op completes one cycle after accept.
        foreach (vecs[i]) begin
            b_instr = vecs[i].ins; b_rs1 = vecs[i].x; b_in_valid = 1'b1;
            @(negedge clk);
            chk({"barrel_", vecs[i].name, "_ready"}, b_in_ready, 1);
            @(posedge clk); #2;
            b_in_valid = 1'b0;
            @(negedge clk);
            chk({"barrel_", vecs[i].name, "_valid"}, b_out_valid, 1);
            chk({"barrel_", vecs[i].name, "_result"}, b_result, vecs[i].er);
            chk({"barrel_", vecs[i].name, "_illegal"}, b_illegal, vecs[i].ei);
            @(posedge clk); #2;
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
